// File: rtl/superio_pkg.sv
// Shared definitions for the superio PS/2 keyboard block: register map,
// STATUS/CTRL bit positions, receive FSM states and the CTRL reset value.
`timescale 1ns/1ps
package superio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_RDY  = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_PERR = 2;
  localparam int ST_FERR = 3;
  localparam int ST_FULL = 4;
  localparam int ST_IRQ  = 7;

  localparam int CT_RXIE  = 0;
  localparam int CT_ERRIE = 1;
  localparam int CT_EN    = 2;

  localparam logic [7:0] CTRL_RST = 8'h04;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2kbd_rx.sv
// PS/2 frame receiver: pin synchronizers, PS2CLK glitch filter, frame FSM.
// Optional frame watchdog is built when PS2KBD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ps2kbd_rx
  import superio_pkg::*;
#(
  parameter int FILT_LEN = 4
`ifdef PS2KBD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       perr_p,
  output logic       ferr_p
);

  localparam int FW = $clog2(FILT_LEN + 1);

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            fall;
  rx_state_e       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            par_ok_q, par_ok_d;
  logic            rx_valid_q, rx_valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
`ifdef PS2KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   tcnt_q, tcnt_d;
`endif

  // The filtered clock follows the synchronized pin only after FILT_LEN equal samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = clk_s2_q;
      else                             fcnt_d = fcnt_q + FW'(1);
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    par_ok_d   = par_ok_q;
    rx_valid_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    if (!en) begin
      state_d = RX_IDLE;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = RX_DATA;
            bitcnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = odd_parity_ok(shift_q, dat_s2_q);
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          rx_valid_d = dat_s2_q & par_ok_q;
          ferr_d     = ~dat_s2_q;
          perr_d     = ~par_ok_q;
          state_d    = RX_IDLE;
        end
      endcase
    end
`ifdef PS2KBD_TIMEOUT_EN
    // Watchdog counts cycles since the last falling edge while a frame is open.
    tcnt_d = '0;
    if (en && state_q != RX_IDLE && !fall) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = RX_IDLE;
        ferr_d  = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_ok_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef PS2KBD_TIMEOUT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      clk_s1_q   <= ps2clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2dat;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_ok_q   <= par_ok_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef PS2KBD_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  assign rx_byte  = shift_q;
  assign rx_valid = rx_valid_q;
  assign perr_p   = perr_q;
  assign ferr_p   = ferr_q;

endmodule

// File: rtl/ps2kbd.sv
// PS/2 keyboard peripheral: scan-code FIFO, DATA/STATUS/CTRL registers, irq.
// Define PS2KBD_TIMEOUT_EN to build the receive-frame watchdog.
`timescale 1ns/1ps
module ps2kbd
  import superio_pkg::*;
#(
  parameter int CLK_HZ      = 1000000,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = CLK_HZ / 500,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ps2clk,
  input  logic       ps2dat
);

  localparam int PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 1 || FILT_LEN < 1) begin : g_bad_cfg
    $error("ps2kbd: invalid parameter set");
  end

  logic [7:0]  rx_byte;
  logic        rx_valid, perr_p, ferr_p;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic        ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pop_arm_q, pop_arm_d;
  logic        empty, full, bus_rd, bus_wr, pop_do, push_ok, ovr_set;
  logic [7:0]  status;

  ps2kbd_rx #(
    .FILT_LEN(FILT_LEN)
`ifdef PS2KBD_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctrl_q[CT_EN]),
    .ps2clk   (ps2clk),
    .ps2dat   (ps2dat),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .perr_p   (perr_p),
    .ferr_p   (ferr_p)
  );

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PW+1)'(FIFO_DEPTH));
  assign bus_rd = cs & rw;
  assign bus_wr = cs & ~rw;
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  assign pop_do  = pop_arm_q & ~empty;
  assign push_ok = rx_valid & (~full | pop_do);
  assign ovr_set = rx_valid & full & ~pop_do;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_arm_d = bus_rd && (AD == REG_DATA);
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_byte;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_do) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_do)      count_d = count_q + (PW+1)'(1);
    else if (pop_do && !push_ok) count_d = count_q - (PW+1)'(1);
  end

  // Error flags: write-one-to-clear, with a new event winning over a clear.
  always_comb begin
    ovr_d  = ovr_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ctrl_d = ctrl_q;
    if (bus_wr && AD == REG_STATUS) begin
      if (DI[ST_OVR])  ovr_d  = 1'b0;
      if (DI[ST_PERR]) perr_d = 1'b0;
      if (DI[ST_FERR]) ferr_d = 1'b0;
    end
    if (bus_wr && AD == REG_CTRL) ctrl_d = DI[2:0];
    if (ovr_set) ovr_d  = 1'b1;
    if (perr_p)  perr_d = 1'b1;
    if (ferr_p)  ferr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ctrl_q    <= CTRL_RST[2:0];
      pop_arm_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ctrl_q    <= ctrl_d;
      pop_arm_q <= pop_arm_d;
    end
  end

  assign irq = (ctrl_q[CT_RXIE] & ~empty) | (ctrl_q[CT_ERRIE] & (ovr_q | perr_q | ferr_q));

  always_comb begin
    status          = 8'h00;
    status[ST_RDY]  = ~empty;
    status[ST_OVR]  = ovr_q;
    status[ST_PERR] = perr_q;
    status[ST_FERR] = ferr_q;
    status[ST_FULL] = full;
    status[ST_IRQ]  = irq;
  end

  always_comb begin
    case (AD)
      REG_DATA:   DO = empty ? 8'h00 : mem_q[rd_ptr_q];
      REG_STATUS: DO = status;
      REG_CTRL:   DO = {5'b00000, ctrl_q};
      default:    DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ps2kbd.sv
// Bench for ps2kbd: drives PS/2 frames and bus cycles; DATA reads are
// checked by a monitor against a queue of expected scan codes.
`timescale 1ns/1ps
module tb_ps2kbd;
  import superio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ad = 2'd0;
  logic [7:0] di = 8'h00;
  logic [7:0] do_w;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       irq;
  logic       ps2clk = 1'b1;
  logic       ps2dat = 1'b1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rv;

  // ---------------- clock / reset ----------------
  always #500 clk = ~clk;

  ps2kbd dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .AD     (ad),
    .DI     (di),
    .DO     (do_w),
    .rw     (rw),
    .cs     (cs),
    .irq    (irq),
    .ps2clk (ps2clk),
    .ps2dat (ps2dat)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; ad = a; di = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; ad = a;
    @(posedge clk);
    #1 v = do_w;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    logic [7:0] v;
    reg_read(REG_STATUS, v);
    check(name, v, exp);
  endtask

  task automatic read_data();
    logic [7:0] v;
    reg_read(REG_DATA, v);
  endtask

  // One PS/2 bit at ~12 kHz; pop_here places a DATA read so its pop lands
  // on the same clk edge as the push caused by this falling edge.
  task automatic ps2_edge(input logic b, input bit pop_here);
    @(negedge clk);
    ps2dat = b;
    idle(20);
    ps2clk = 1'b0;
    if (pop_here) begin
      idle(5);
      cs = 1'b1; rw = 1'b1; ad = REG_DATA;
      idle(1);
      cs = 1'b0;
      idle(36);
    end else begin
      idle(42);
    end
    ps2clk = 1'b1;
    idle(22);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last, input bit pop_stop);
    for (int i = first; i < last; i++) ps2_edge(f[i], pop_stop && (i == 10));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit keep, input bit pop_stop);
    if (keep) exp_q.push_back(b);
    send_bits(make_frame(b, bad_par), 0, 11, pop_stop);
    idle(10);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (cs && rw && ad == REG_DATA) begin
      if (exp_q.size() > 0) check("data", do_w, exp_q.pop_front());
      else                  check("data_empty", do_w, 8'h00);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle(5);
    rst_n = 1'b1;
    idle(3);

    // Reset state
    check_status("rst_status", 8'h00);
    reg_read(REG_CTRL, rv);
    check("rst_ctrl", rv, 8'h04);
    reg_read(REG_RSVD, rv);
    check("rst_rsvd", rv, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    read_data();

    // Good frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_status("rx_rdy", 8'h01);
    check("rx_irq_off", {7'b0, irq}, 8'h00);
    reg_write(REG_CTRL, 8'h05);
    check("rx_irq_on", {7'b0, irq}, 8'h01);
    read_data();
    check_status("rx_popped", 8'h00);
    check("rx_irq_clr", {7'b0, irq}, 8'h00);
    reg_write(REG_CTRL, 8'h04);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_status("perr_status", 8'h04);
    reg_write(REG_CTRL, 8'h06);
    check("perr_irq", {7'b0, irq}, 8'h01);
    check_status("perr_status_irq", 8'h84);
    read_data();
    reg_write(REG_STATUS, 8'h04);
    check_status("perr_cleared", 8'h00);
    check("perr_irq_clr", {7'b0, irq}, 8'h00);
    reg_write(REG_CTRL, 8'h04);

    // Overflow: nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, i <= 8, 1'b0);
    check_status("ovf_status", 8'h13);
    for (int i = 0; i < 8; i++) read_data();
    check_status("ovf_drained", 8'h02);
    read_data();
    reg_write(REG_STATUS, 8'h02);
    check_status("ovf_cleared", 8'h00);

    // Push and pop on the same edge with three entries queued
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b1);
    check_status("same_edge_status", 8'h01);
    for (int i = 0; i < 3; i++) read_data();
    check_status("same_edge_empty", 8'h00);

    // Short glitch on ps2clk while idle
    @(negedge clk);
    ps2clk = 1'b0;
    idle(2);
    ps2clk = 1'b1;
    idle(10);
    check("glitch_state", 8'(dut.u_rx.state_q), 8'(RX_IDLE));
    check_status("glitch_status", 8'h00);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    read_data();

    // Receiver disabled
    reg_write(REG_CTRL, 8'h00);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    check_status("en_off_status", 8'h00);
    reg_write(REG_CTRL, 8'h04);

    // Truncated frame followed by 3 ms of silence
    exp_q.push_back(8'h5A);
    send_bits(make_frame(8'h5A, 1'b0), 0, 5, 1'b0);
    idle(3000);
`ifdef PS2KBD_TIMEOUT_EN
    check_status("timeout_ferr", 8'h08);
    reg_write(REG_STATUS, 8'h08);
    send_bits(make_frame(8'h5A, 1'b0), 0, 11, 1'b0);
`else
    check_status("no_timeout", 8'h00);
    send_bits(make_frame(8'h5A, 1'b0), 5, 11, 1'b0);
`endif
    idle(10);
    check_status("after_timeout_rdy", 8'h01);
    read_data();
    check_status("final_status", 8'h00);

    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
